// File: rtl/mem_bus_unit.sv
// Load/store unit bridging the pipeline to a single-master memory bus with ACKD_n wait states.
// Decodes size/legality and aligns lanes at acceptance, then runs one bus cycle per request.
module mem_bus_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_cause,
  output logic [ADDR_W-1:0] DAD,
  output logic              MREQ,
  output logic              WRITE,
  output logic [1:0]        SIZE,
  output logic [DATA_W-1:0] DDT_o,
  output logic              DDT_oe,
  input  logic [DATA_W-1:0] DDT_i,
  input  logic              ACKD_n
);

  localparam int LANE_W = $clog2(DATA_W/8);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE   = 2'b00;
  localparam logic [1:0] S_ACCESS = 2'b01;
  localparam logic [1:0] S_RESP   = 2'b10;

  localparam logic [1:0] SZ_WORD  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_DWORD = 2'b10;
  localparam logic [1:0] SZ_BYTE  = 2'b11;

  localparam logic [1:0] C_OK      = 2'b00;
  localparam logic [1:0] C_MISALGN = 2'b01;
  localparam logic [1:0] C_ILLEGAL = 2'b10;
  localparam logic [1:0] C_TIMEOUT = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        funct3;
    logic              write;
    logic [1:0]        size;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  logic [1:0]        state_q, state_d;
  acc_t              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        cause_q, cause_d;

  logic              dec_legal;
  logic              dec_misalgn;
  logic [1:0]        dec_size;
  logic [DATA_W-1:0] wdata_shift;
  logic [DATA_W-1:0] rd_shift;
  logic [DATA_W-1:0] load_ext;

  // Request decode; the doubleword and word-unsigned encodings exist only on a 64-bit bus
  always_comb begin
    dec_legal = 1'b1;
    dec_size  = SZ_WORD;
    case (req_funct3)
      3'b000, 3'b100: dec_size = SZ_BYTE;
      3'b001, 3'b101: dec_size = SZ_HALF;
      3'b010:         dec_size = SZ_WORD;
      3'b011: begin
        dec_size  = SZ_DWORD;
        dec_legal = (DATA_W == 64);
      end
      3'b110: begin
        dec_size  = SZ_WORD;
        dec_legal = (DATA_W == 64);
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (dec_size)
      SZ_HALF:  dec_misalgn = req_addr[0];
      SZ_WORD:  dec_misalgn = (req_addr[1:0] != 2'b00);
      SZ_DWORD: dec_misalgn = (req_addr[2:0] != 3'b000);
      default:  dec_misalgn = 1'b0;
    endcase
  end

  assign wdata_shift = req_wdata << {req_addr[LANE_W-1:0], 3'b000};

  // Load path: bring the addressed lane down to bit 0, then extend by funct3
  assign rd_shift = DDT_i >> {acc_q.addr[LANE_W-1:0], 3'b000};

  always_comb begin
    case (acc_q.funct3)
      3'b000:  load_ext = DATA_W'($signed(rd_shift[7:0]));
      3'b100:  load_ext = DATA_W'(rd_shift[7:0]);
      3'b001:  load_ext = DATA_W'($signed(rd_shift[15:0]));
      3'b101:  load_ext = DATA_W'(rd_shift[15:0]);
      3'b010:  load_ext = DATA_W'($signed(rd_shift[31:0]));
      3'b110:  load_ext = DATA_W'(rd_shift[31:0]);
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          acc_d.addr   = req_addr;
          acc_d.funct3 = req_funct3;
          acc_d.write  = req_write;
          acc_d.size   = dec_size;
          acc_d.wdata  = wdata_shift;
          rdata_d      = '0;
          // Illegal encoding outranks misalignment; neither starts a bus cycle
          if (!dec_legal) begin
            cause_d = C_ILLEGAL;
            state_d = S_RESP;
          end else if (dec_misalgn) begin
            cause_d = C_MISALGN;
            state_d = S_RESP;
          end else begin
            cause_d = C_OK;
            cnt_d   = '0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (ACKD_n) begin
          rdata_d = acc_q.write ? '0 : load_ext;
          cause_d = C_OK;
          state_d = S_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          rdata_d = '0;
          cause_d = C_TIMEOUT;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      cause_q <= C_OK;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      cause_q <= cause_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign stall      = ((state_q == S_IDLE) && req_valid) || (state_q == S_ACCESS);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = rdata_q;
  assign resp_cause = cause_q;

  assign DAD    = acc_q.addr;
  assign MREQ   = (state_q == S_ACCESS);
  assign WRITE  = acc_q.write;
  assign SIZE   = acc_q.size;
  assign DDT_o  = acc_q.wdata;
  assign DDT_oe = (state_q == S_ACCESS) && acc_q.write;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Bench for mem_bus_unit: a 32-bit unit with TIMEOUT=4 and a 64-bit unit with the timeout disabled.
// Table vectors feed a response scoreboard; reset-related corners are hand-sequenced.
module tb_mem_bus_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel, req_valid, req_write, ackd_n;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, ddt_i;
  logic        rv_a, rv_b;

  logic        a_ready, a_stall, a_rv, a_mreq, a_write, a_oe;
  logic [31:0] a_rdata, a_dad, a_ddt_o;
  logic [1:0]  a_cause, a_size;
  logic        b_ready, b_stall, b_rv, b_mreq, b_write, b_oe;
  logic [63:0] b_rdata, b_ddt_o;
  logic [31:0] b_dad;
  logic [1:0]  b_cause, b_size;

  logic        o_ready, o_stall, o_rv, o_mreq, o_write, o_oe;
  logic [63:0] o_rdata, o_ddt_o;
  logic [31:0] o_dad;
  logic [1:0]  o_cause, o_size;

  assign rv_a = req_valid & ~sel;
  assign rv_b = req_valid & sel;

  mem_bus_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata[31:0]), .req_ready(a_ready), .stall(a_stall),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_cause(a_cause), .DAD(a_dad), .MREQ(a_mreq),
    .WRITE(a_write), .SIZE(a_size), .DDT_o(a_ddt_o), .DDT_oe(a_oe), .DDT_i(ddt_i[31:0]),
    .ACKD_n(ackd_n));

  mem_bus_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(0)) u_b (
    .clk(clk), .rst(rst), .req_valid(rv_b), .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_ready), .stall(b_stall),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_cause(b_cause), .DAD(b_dad), .MREQ(b_mreq),
    .WRITE(b_write), .SIZE(b_size), .DDT_o(b_ddt_o), .DDT_oe(b_oe), .DDT_i(ddt_i),
    .ACKD_n(ackd_n));

  always_comb begin
    if (sel === 1'b1) begin
      o_ready = b_ready; o_stall = b_stall; o_rv = b_rv; o_mreq = b_mreq; o_write = b_write;
      o_oe = b_oe; o_rdata = b_rdata; o_ddt_o = b_ddt_o; o_dad = b_dad; o_cause = b_cause;
      o_size = b_size;
    end else begin
      o_ready = a_ready; o_stall = a_stall; o_rv = a_rv; o_mreq = a_mreq; o_write = a_write;
      o_oe = a_oe; o_rdata = {32'b0, a_rdata}; o_ddt_o = {32'b0, a_ddt_o}; o_dad = a_dad;
      o_cause = a_cause; o_size = a_size;
    end
  end

  typedef struct {
    bit          sel;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [63:0] ddt_i;
    int          waits;
    logic [1:0]  cause;
    logic [63:0] rdata;
    logic [1:0]  size;
    logic [63:0] ddt_o;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0]  cause;
    logic [63:0] rdata;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every completion pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (a_rv === 1'b1 || b_rv === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=resp_valid expected=none");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_cause", {62'b0, o_cause}, {62'b0, e.cause});
        chk("resp_rdata", o_rdata, e.rdata);
      end
    end
  end

  task automatic add(input bit s, input bit wr, input logic [2:0] f3, input logic [31:0] ad,
                     input logic [63:0] wd, input logic [63:0] di, input int w,
                     input logic [1:0] c, input logic [63:0] rd, input logic [1:0] sz,
                     input logic [63:0] dout, input int lat);
    vec_t v;
    v.sel = s; v.wr = wr; v.f3 = f3; v.addr = ad; v.wdata = wd; v.ddt_i = di; v.waits = w;
    v.cause = c; v.rdata = rd; v.size = sz; v.ddt_o = dout; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic run(input vec_t v, input bit hold);
    exp_t e;
    int   a, lat, mreqs;
    bit   got;
    @(negedge clk);
    sel = v.sel; req_write = v.wr; req_funct3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; ddt_i = v.ddt_i; ackd_n = (v.waits == 0);
    req_valid = 1'b1;
    #1;
    chk("ready_idle", {63'b0, o_ready}, 64'd1);
    chk("stall_req", {63'b0, o_stall}, 64'd1);
    e.cause = v.cause; e.rdata = v.rdata;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (hold) req_addr = 32'hFFF0;
    else      req_valid = 1'b0;
    a = 0; got = 0; mreqs = 0;
    for (lat = 1; lat <= 60; lat++) begin
      @(negedge clk);
      if (o_rv === 1'b1) begin
        got = 1;
        break;
      end
      if (o_mreq === 1'b1) begin
        mreqs++;
        chk("dad", {32'b0, o_dad}, {32'b0, v.addr});
        chk("size", {62'b0, o_size}, {62'b0, v.size});
        chk("write", {63'b0, o_write}, {63'b0, v.wr});
        chk("ddt_o", o_ddt_o, v.ddt_o);
        chk("ddt_oe", {63'b0, o_oe}, {63'b0, v.wr});
        chk("stall_access", {63'b0, o_stall}, 64'd1);
        chk("ready_busy", {63'b0, o_ready}, 64'd0);
      end
      ackd_n = (a >= v.waits);
      a++;
    end
    chk("resp_seen", {63'b0, got}, 64'd1);
    if (!got) exp_q.delete();
    chk("latency", 64'(lat), 64'(v.lat));
    chk("mreq_cycles", 64'(mreqs), 64'(v.lat - 1));
    chk("mreq_resp", {63'b0, o_mreq}, 64'd0);
    chk("stall_resp", {63'b0, o_stall}, 64'd0);
    chk("ready_resp", {63'b0, o_ready}, 64'd0);
    req_valid = 1'b0;
    ackd_n = 1'b1;
    @(negedge clk);
    chk("resp_pulse", {63'b0, o_rv}, 64'd0);
    chk("ready_back", {63'b0, o_ready}, 64'd1);
  endtask

  initial begin
    // 32-bit unit, TIMEOUT=4
    add(0, 0, 3'b000, 32'h103, 0, 64'h80FF_FFFF, 0, 2'b00, 64'hFFFF_FF80, 2'b11, 0, 2);
    add(0, 1, 3'b001, 32'h202, 64'h1234, 0, 3, 2'b00, 0, 2'b01, 64'h1234_0000, 5);
    add(0, 0, 3'b010, 32'h101, 0, 0, 0, 2'b01, 0, 2'b00, 0, 1);
    add(0, 0, 3'b011, 32'h100, 0, 0, 0, 2'b10, 0, 2'b00, 0, 1);
    add(0, 0, 3'b111, 32'h101, 0, 0, 0, 2'b10, 0, 2'b00, 0, 1);
    add(0, 0, 3'b110, 32'h100, 0, 0, 0, 2'b10, 0, 2'b00, 0, 1);
    add(0, 0, 3'b001, 32'h003, 0, 0, 0, 2'b01, 0, 2'b00, 0, 1);
    add(0, 0, 3'b100, 32'h102, 0, 64'h12AB_3456, 0, 2'b00, 64'hAB, 2'b11, 0, 2);
    add(0, 0, 3'b001, 32'h102, 0, 64'h8001_7FFF, 1, 2'b00, 64'hFFFF_8001, 2'b01, 0, 3);
    add(0, 0, 3'b101, 32'h000, 0, 64'h1234_F00D, 0, 2'b00, 64'hF00D, 2'b01, 0, 2);
    add(0, 0, 3'b010, 32'h004, 0, 64'hDEAD_BEEF, 2, 2'b00, 64'hDEAD_BEEF, 2'b00, 0, 4);
    add(0, 1, 3'b010, 32'h008, 64'hCAFE_BABE, 64'hFFFF_FFFF, 0, 2'b00, 0, 2'b00, 64'hCAFE_BABE, 2);
    add(0, 1, 3'b000, 32'h001, 64'hA5, 0, 0, 2'b00, 0, 2'b11, 64'hA500, 2);
    add(0, 0, 3'b010, 32'h010, 0, 64'h1111_1111, 1000, 2'b11, 0, 2'b00, 0, 5);
    add(0, 0, 3'b010, 32'h014, 0, 64'h7654_3210, 3, 2'b00, 64'h7654_3210, 2'b00, 0, 5);
    // 64-bit unit, timeout disabled
    add(1, 0, 3'b110, 32'h4, 0, 64'h8000_0001_1234_5678, 0, 2'b00, 64'h0000_0000_8000_0001, 2'b00, 0, 2);
    add(1, 0, 3'b010, 32'h4, 0, 64'h8000_0001_1234_5678, 0, 2'b00, 64'hFFFF_FFFF_8000_0001, 2'b00, 0, 2);
    add(1, 0, 3'b011, 32'h8, 0, 64'h0123_4567_89AB_CDEF, 0, 2'b00, 64'h0123_4567_89AB_CDEF, 2'b10, 0, 2);
    add(1, 0, 3'b011, 32'hC, 0, 0, 0, 2'b01, 0, 2'b00, 0, 1);
    add(1, 1, 3'b011, 32'h0, 64'h1122_3344_5566_7788, 0, 0, 2'b00, 0, 2'b10, 64'h1122_3344_5566_7788, 2);
    add(1, 1, 3'b000, 32'h5, 64'h7F, 0, 0, 2'b00, 0, 2'b11, 64'h0000_7F00_0000_0000, 2);
    add(1, 0, 3'b010, 32'h0, 0, 64'h42, 20, 2'b00, 64'h42, 2'b00, 0, 22);
    add(1, 0, 3'b111, 32'h0, 0, 0, 0, 2'b10, 0, 2'b00, 0, 1);
    add(1, 0, 3'b000, 32'h7, 0, 64'h80AA_0000_0000_0000, 0, 2'b00, 64'hFFFF_FFFF_FFFF_FF80, 2'b11, 0, 2);
    add(1, 0, 3'b101, 32'h6, 0, 64'hBEEF_0000_0000_0000, 0, 2'b00, 64'hBEEF, 2'b01, 0, 2);

    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; ddt_i = '0; ackd_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_mreq", {63'b0, o_mreq}, 64'd0);
      chk("rst_write_oe", {62'b0, o_write, o_oe}, 64'd0);
      chk("rst_resp_valid", {63'b0, o_rv}, 64'd0);
      chk("rst_dad", {32'b0, o_dad}, 64'd0);
      chk("rst_ddt_o", o_ddt_o, 64'd0);
      chk("rst_rdata", o_rdata, 64'd0);
      chk("rst_size_cause", {60'b0, o_size, o_cause}, 64'd0);
      chk("rst_ready_stall", {62'b0, o_ready, o_stall}, 64'd2);
    end
    rst = 1'b0;

    foreach (vecs[i]) run(vecs[i], 1'b0);

    // Request held asserted across a waited store must be ignored until IDLE
    run(vecs[1], 1'b1);

    // Reset in the middle of a waited access aborts it without a completion pulse
    @(negedge clk);
    sel = 1'b0; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; ackd_n = 1'b0;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_mreq_before", {63'b0, o_mreq}, 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_mreq_after", {63'b0, o_mreq}, 64'd0);
    chk("abort_ready", {63'b0, o_ready}, 64'd1);
    ackd_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_resp", {63'b0, o_rv}, 64'd0);
    end
    run(vecs[0], 1'b0);
    run(vecs[15], 1'b0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
